mor1kx_pic_irq_req: RTL



---
 rtl/mor1kx_pic_irq_req_pkg.sv | 23 ++
 rtl/mor1kx_prio_enc32.sv | 19 +
 rtl/mor1kx_pic_irq_req.sv | 102 ++++++++++
 3 files changed

// File: rtl/mor1kx_pic_irq_req_pkg.sv
// rtl/mor1kx_pic_irq_req_pkg.sv - shared types and constants for the PIC interrupt request stage
package mor1kx_pic_irq_req_pkg;

  localparam int IRQ_VEC_W  = 5;
  localparam int HOLD_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_HOLD = 2'd2
  } irq_state_e;

  // Mask with the lowest `width` bits set; width 0 yields an empty mask.
  function automatic logic [31:0] low_mask(input int width);
    logic [31:0] m;
    m = '0;
    for (int i = 0; i < 32; i++) begin
      if (i < width) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/mor1kx_prio_enc32.sv
// rtl/mor1kx_prio_enc32.sv - 32-to-5 fixed-priority encoder, lowest set index wins
module mor1kx_prio_enc32
  import mor1kx_pic_irq_req_pkg::*;
(
  input  logic [31:0]          i_req,
  output logic                 o_valid,
  output logic [IRQ_VEC_W-1:0] o_idx
);

  always_comb begin
    o_valid = |i_req;
    o_idx   = '0;
    // Scan downwards so the lowest set bit is the last one written.
    for (int i = 31; i >= 0; i--) begin
      if (i_req[i]) o_idx = i[IRQ_VEC_W-1:0];
    end
  end

endmodule

// File: rtl/mor1kx_pic_irq_req.sv
// rtl/mor1kx_pic_irq_req.sv - arbitrates PIC lines into one req/ack interrupt request with hold-off
module mor1kx_pic_irq_req
  import mor1kx_pic_irq_req_pkg::*;
#(
  parameter int OPTION_PIC_NMI_WIDTH = 0,
  parameter int OPTION_IRQ_HOLDOFF   = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [31:0]          picsr_i,
  input  logic [31:0]          picmr_i,
  input  logic                 sr_iee_i,
  output logic                 irq_req_o,
  output logic [IRQ_VEC_W-1:0] irq_vec_o,
  output logic                 irq_nmi_o,
  input  logic                 irq_ack_i,
  output logic                 irq_pending_o
);

  localparam logic [31:0]           NMI_MASK  = low_mask(OPTION_PIC_NMI_WIDTH);
  localparam logic [HOLD_CNT_W-1:0] HOLD_LOAD = HOLD_CNT_W'(OPTION_IRQ_HOLDOFF);

  irq_state_e                r_state;
  irq_state_e                w_state_nxt;
  logic [HOLD_CNT_W-1:0]     r_cnt;
  logic [HOLD_CNT_W-1:0]     w_cnt_nxt;
  logic [IRQ_VEC_W-1:0]      r_vec;
  logic [IRQ_VEC_W-1:0]      w_vec_nxt;
  logic                      r_nmi;
  logic                      w_nmi_nxt;
  logic                      r_req;
  logic                      r_pending;

  logic [31:0]               w_pending;
  logic [31:0]               w_eligible;
  logic                      w_enc_valid;
  logic [IRQ_VEC_W-1:0]      w_enc_idx;

  assign w_pending  = picsr_i & picmr_i;
  assign w_eligible = sr_iee_i ? w_pending : (w_pending & NMI_MASK);

  mor1kx_prio_enc32 u_prio_enc (
    .i_req   (w_eligible),
    .o_valid (w_enc_valid),
    .o_idx   (w_enc_idx)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_vec_nxt   = r_vec;
    w_nmi_nxt   = r_nmi;
    case (r_state)
      ST_IDLE: begin
        if (w_enc_valid) begin
          w_state_nxt = ST_REQ;
          w_vec_nxt   = w_enc_idx;
          w_nmi_nxt   = NMI_MASK[w_enc_idx];
        end
      end
      ST_REQ: begin
        // Ack takes precedence over a simultaneous withdrawal.
        if (irq_ack_i) begin
          w_state_nxt = ST_HOLD;
          w_cnt_nxt   = HOLD_LOAD;
        end else if (!w_eligible[r_vec]) begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_HOLD: begin
        // A load of N keeps HOLD for N cycles; a load of 0 still costs one.
        if (r_cnt != '0) w_cnt_nxt = r_cnt - 1'b1;
        if (r_cnt <= HOLD_CNT_W'(1)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= ST_IDLE;
      r_cnt     <= '0;
      r_vec     <= '0;
      r_nmi     <= 1'b0;
      r_req     <= 1'b0;
      r_pending <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_cnt     <= w_cnt_nxt;
      r_vec     <= w_vec_nxt;
      r_nmi     <= w_nmi_nxt;
      r_req     <= (w_state_nxt == ST_REQ);
      r_pending <= |w_pending;
    end
  end

  assign irq_req_o     = r_req;
  assign irq_vec_o     = r_vec;
  assign irq_nmi_o     = r_nmi;
  assign irq_pending_o = r_pending;

endmodule
